// File: rtl/mem_load_unit_if.sv
// Byte-wide external memory read port used by mem_load_unit.
// The master issues mem_rd/mem_addr and waits for mem_ready.
interface mem_load_unit_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_load_unit.sv
// mem_load_unit: loads 1 or 2 bytes from byte-wide memory and strobes them into the register file.
// Optional per-byte read timeout with a sticky err flag: define MEM_LOAD_TIMEOUT_EN.

package register_types;
    typedef enum logic [3:0] {NONE, A, B, C, D, E, H, L, M, SP, IP} name;
endpackage

module mem_load_unit #(
    parameter int ADDR_W         = 17,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_word,
    input  register_types::name req_dest,
    output logic                busy,
    output logic                done,
    mem_load_unit_if.master     mem,
    output register_types::name mem_dest_select,
    output logic [7:0]          mem_dest,
    output logic                mem_dest_hi,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, READ, STROBE} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_load_unit: TIMEOUT_CYCLES must be at least 1");
    end

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr, addr_next;
    logic                word, word_next;
    logic                phase_hi, phase_hi_next;
    register_types::name dest, dest_next;
    logic [7:0]          data, data_next;
    logic                rd, rd_next;
    logic                busy_next, done_next, strobe_next;
    register_types::name select_next;
    logic [7:0]          mem_dest_next;
    logic                hi_next;

`ifdef MEM_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             err_next;
`endif

    // The current address register is the bus address; it is only meaningful while mem_rd=1.
    assign mem.mem_addr = addr;
    assign mem.mem_rd   = rd;

    // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next    = state;
        addr_next     = addr;
        word_next     = word;
        phase_hi_next = phase_hi;
        dest_next     = dest;
        data_next     = data;
`ifdef MEM_LOAD_TIMEOUT_EN
        cnt_next      = cnt;
        err_next      = err;
`endif

        case (state)
            IDLE: begin
                if (req) begin
                    addr_next     = req_addr;
                    word_next     = req_word;
                    dest_next     = req_dest;
                    phase_hi_next = 1'b0;
                    state_next    = READ;
`ifdef MEM_LOAD_TIMEOUT_EN
                    cnt_next      = '0;
`endif
                end
            end
            READ: begin
                if (mem.mem_ready) begin
                    data_next  = mem.mem_rdata;
                    state_next = STROBE;
                end
`ifdef MEM_LOAD_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
`endif
            end
            STROBE: begin
                if (word && !phase_hi) begin
                    addr_next     = addr + 1'b1;
                    phase_hi_next = 1'b1;
                    state_next    = READ;
`ifdef MEM_LOAD_TIMEOUT_EN
                    cnt_next      = '0;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_next     = (state_next != IDLE);
        rd_next       = (state_next == READ);
        strobe_next   = (state_next == STROBE);
        done_next     = strobe_next && !(word_next && !phase_hi_next);
        select_next   = strobe_next ? dest_next : register_types::NONE;
        mem_dest_next = strobe_next ? data_next : 8'h00;
        hi_next       = strobe_next && phase_hi_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            addr            <= '0;
            word            <= 1'b0;
            phase_hi        <= 1'b0;
            dest            <= register_types::NONE;
            data            <= 8'h00;
            rd              <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            mem_dest_select <= register_types::NONE;
            mem_dest        <= 8'h00;
            mem_dest_hi     <= 1'b0;
`ifdef MEM_LOAD_TIMEOUT_EN
            cnt             <= '0;
            err             <= 1'b0;
`endif
        end else begin
            state           <= state_next;
            addr            <= addr_next;
            word            <= word_next;
            phase_hi        <= phase_hi_next;
            dest            <= dest_next;
            data            <= data_next;
            rd              <= rd_next;
            busy            <= busy_next;
            done            <= done_next;
            mem_dest_select <= select_next;
            mem_dest        <= mem_dest_next;
            mem_dest_hi     <= hi_next;
`ifdef MEM_LOAD_TIMEOUT_EN
            cnt             <= cnt_next;
            err             <= err_next;
`endif
        end
    end

`ifndef MEM_LOAD_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed testbench for mem_load_unit: byte/word loads, wait states, address wrap,
// mid-load reset, ignored requests while busy, back-to-back loads and the optional timeout.
module tb_mem_load_unit;
    localparam int ADDR_W = 17;

    logic                clk = 1'b0;
    logic                reset;
    logic                req;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_word;
    register_types::name req_dest;
    logic                busy, done, mem_dest_hi, err;
    register_types::name mem_dest_select;
    logic [7:0]          mem_dest;

    int passed = 0;
    int total  = 0;

    mem_load_unit_if #(.ADDR_W(ADDR_W)) mem ();

    mem_load_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(15)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_addr        (req_addr),
        .req_word        (req_word),
        .req_dest        (req_dest),
        .busy            (busy),
        .done            (done),
        .mem             (mem),
        .mem_dest_select (mem_dest_select),
        .mem_dest        (mem_dest),
        .mem_dest_hi     (mem_dest_hi),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status = {busy, done, mem_rd, mem_dest_hi, mem_dest_select, mem_dest}
    task automatic expect_read(input string tag, input logic [ADDR_W-1:0] exp_addr);
        logic [15+ADDR_W:0] obs, exp;
        obs = {busy, done, mem.mem_rd, mem_dest_hi, mem_dest_select, mem_dest, mem.mem_addr};
        exp = {1'b1, 1'b0, 1'b1, 1'b0, register_types::NONE, 8'h00, exp_addr};
        total++;
        if (obs !== exp) $display("FAIL %s read: got %h want %h", tag, obs, exp);
        else passed++;
    endtask

    task automatic expect_strobe(input string tag, input register_types::name sel,
                                 input logic [7:0] d, input logic hi, input logic dn);
        logic [15:0] obs, exp;
        obs = {busy, done, mem.mem_rd, mem_dest_hi, mem_dest_select, mem_dest};
        exp = {1'b1, dn, 1'b0, hi, sel, d};
        total++;
        if (obs !== exp) $display("FAIL %s strobe: got %h want %h", tag, obs, exp);
        else passed++;
    endtask

    task automatic expect_idle(input string tag);
        logic [15:0] obs, exp;
        obs = {busy, done, mem.mem_rd, mem_dest_hi, mem_dest_select, mem_dest};
        exp = {1'b0, 1'b0, 1'b0, 1'b0, register_types::NONE, 8'h00};
        total++;
        if (obs !== exp) $display("FAIL %s idle: got %h want %h", tag, obs, exp);
        else passed++;
    endtask

    // Present a request for one cycle; returns in the first READ cycle.
    task automatic start_load(input logic [ADDR_W-1:0] a, input logic w, input register_types::name d);
        req      = 1'b1;
        req_addr = a;
        req_word = w;
        req_dest = d;
        tick();
        req = 1'b0;
    endtask

    // Hold mem_ready low for `waits` READ cycles, then complete with `d`; returns in the STROBE cycle.
    task automatic serve(input string tag, input int waits, input logic [7:0] d,
                         input logic [ADDR_W-1:0] a);
        for (int i = 0; i < waits; i++) begin
            expect_read(tag, a);
            tick();
        end
        mem.mem_ready = 1'b1;
        mem.mem_rdata = d;
        expect_read(tag, a);
        tick();
        mem.mem_ready = 1'b0;
        mem.mem_rdata = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        expect_idle("reset");
        total++;
        if ({mem.mem_addr, err} !== {{ADDR_W{1'b0}}, 1'b0})
            $display("FAIL reset addr/err: got %h/%b want 0/0", mem.mem_addr, err);
        else passed++;
        tick();
        reset = 1'b0;
        tick();
        expect_idle("after_reset");
    endtask

    task automatic test_byte_load();
        mem.mem_ready = 1'b1;
        mem.mem_rdata = 8'h5A;
        start_load(17'h00100, 1'b0, register_types::M);
        serve("byte", 0, 8'h5A, 17'h00100);
        expect_strobe("byte", register_types::M, 8'h5A, 1'b0, 1'b1);
        tick();
        expect_idle("byte_end");
    endtask

    task automatic test_word_load();
        start_load(17'h01000, 1'b1, register_types::SP);
        serve("word_lo", 2, 8'h34, 17'h01000);
        expect_strobe("word_lo", register_types::SP, 8'h34, 1'b0, 1'b0);
        tick();
        serve("word_hi", 2, 8'h12, 17'h01001);
        expect_strobe("word_hi", register_types::SP, 8'h12, 1'b1, 1'b1);
        tick();
        expect_idle("word_end");
    endtask

    task automatic test_wrap();
        start_load(17'h1FFFF, 1'b1, register_types::IP);
        serve("wrap_lo", 0, 8'hEF, 17'h1FFFF);
        expect_strobe("wrap_lo", register_types::IP, 8'hEF, 1'b0, 1'b0);
        tick();
        serve("wrap_hi", 0, 8'hBE, 17'h00000);
        expect_strobe("wrap_hi", register_types::IP, 8'hBE, 1'b1, 1'b1);
        tick();
        expect_idle("wrap_end");
    endtask

    task automatic test_reset_mid_read();
        start_load(17'h02000, 1'b1, register_types::SP);
        expect_read("rst_mid", 17'h02000);
        tick();
        expect_read("rst_mid_wait", 17'h02000);
        reset = 1'b1;
        #1;
        expect_idle("rst_mid_async");
        total++;
        if (mem.mem_addr !== {ADDR_W{1'b0}})
            $display("FAIL rst_mid addr: got %h want 0", mem.mem_addr);
        else passed++;
        tick();
        reset = 1'b0;
        mem.mem_ready = 1'b1;
        mem.mem_rdata = 8'h66;
        tick();
        expect_idle("rst_mid_ready_ignored");
        tick();
        expect_idle("rst_mid_ready_ignored2");
        mem.mem_ready = 1'b0;
        start_load(17'h00003, 1'b0, register_types::A);
        serve("rst_after", 0, 8'hC3, 17'h00003);
        expect_strobe("rst_after", register_types::A, 8'hC3, 1'b0, 1'b1);
        tick();
        expect_idle("rst_after_end");
    endtask

    task automatic test_req_while_busy();
        start_load(17'h00300, 1'b0, register_types::H);
        req      = 1'b1;
        req_addr = 17'h00777;
        req_word = 1'b1;
        req_dest = register_types::B;
        expect_read("busy_req", 17'h00300);
        tick();
        req = 1'b0;
        serve("busy_req", 1, 8'h11, 17'h00300);
        req = 1'b1;
        expect_strobe("busy_req", register_types::H, 8'h11, 1'b0, 1'b1);
        tick();
        req = 1'b0;
        expect_idle("busy_req_strobe_ignored");
        tick();
        expect_idle("busy_req_not_queued");
    endtask

    task automatic test_back_to_back();
        start_load(17'h0AAAA, 1'b0, register_types::E);
        serve("b2b_first", 0, 8'h77, 17'h0AAAA);
        expect_strobe("b2b_first", register_types::E, 8'h77, 1'b0, 1'b1);
        tick();
        expect_idle("b2b_gap");
        start_load(17'h0AAAB, 1'b0, register_types::D);
        serve("b2b_second", 0, 8'h88, 17'h0AAAB);
        expect_strobe("b2b_second", register_types::D, 8'h88, 1'b0, 1'b1);
        tick();
        expect_idle("b2b_end");
    endtask

    task automatic test_dest_none();
        start_load(17'h00050, 1'b0, register_types::NONE);
        serve("none", 1, 8'h99, 17'h00050);
        expect_strobe("none", register_types::NONE, 8'h99, 1'b0, 1'b1);
        tick();
        expect_idle("none_end");
    endtask

`ifdef MEM_LOAD_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        n = 0;
        start_load(17'h00400, 1'b0, register_types::L);
        while (mem.mem_rd === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++;
        if (n != 15) $display("FAIL timeout read cycles: got %0d want 15", n);
        else passed++;
        expect_idle("timeout_abort");
        total++;
        if (err !== 1'b1) $display("FAIL timeout err: got %b want 1", err);
        else passed++;
        start_load(17'h00401, 1'b0, register_types::L);
        serve("timeout_next", 0, 8'h42, 17'h00401);
        expect_strobe("timeout_next", register_types::L, 8'h42, 1'b0, 1'b1);
        tick();
        total++;
        if (err !== 1'b1) $display("FAIL timeout err sticky: got %b want 1", err);
        else passed++;
    endtask
`else
    task automatic test_err_tied();
        total++;
        if (err !== 1'b0) $display("FAIL err tied: got %b want 0", err);
        else passed++;
    endtask
`endif

    initial begin
        reset         = 1'b0;
        req           = 1'b0;
        req_addr      = '0;
        req_word      = 1'b0;
        req_dest      = register_types::NONE;
        mem.mem_ready = 1'b0;
        mem.mem_rdata = 8'h00;
        #2;
        test_reset();
        test_byte_load();
        test_word_load();
        test_wrap();
        test_reset_mid_read();
        test_req_while_busy();
        test_back_to_back();
        test_dest_none();
`ifdef MEM_LOAD_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
